// File: rtl/intctl.sv
// -----------------------------------------------------------------------------
// intctl -- interrupt controller feeding the sequencer's single INTRQ input.
//
// Collects NLINES asynchronous interrupt sources and turns them into one
// registered request plus a vector. Each line gets a synchroniser, edge or
// level capture, an enable bit and a fixed priority (line 0 highest). The
// sequencer acknowledges with a one-cycle ACK, which latches the winning
// vector. It ends the service routine with a one-cycle EOI.
//
// Optional build macro: INTCTL_NEST_EN
//   defined   : in-service register plus priority mask. Only a strictly
//               higher-priority line may interrupt a line that is in service.
//               EOI retires the highest-priority in-service line.
//   undefined : no in-service register. o_inserv reads 0 and i_eoi is ignored.
//               Nesting is left to the sequencer's own interrupt-enable bit.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_irq_in     raw interrupt sources, active-high, asynchronous
//   i_en_we      enable register write strobe
//   i_en_wd      enable register write data
//   i_ack        sequencer acknowledge pulse (latches vector)
//   i_eoi        sequencer end-of-interrupt pulse
//   o_intrq      registered interrupt request to the sequencer
//   o_vector     {spurious, line[2:0]} latched at ACK
//   o_pending    pending register (status)
//   o_inserv     in-service register (status)
// -----------------------------------------------------------------------------
module intctl #(
    parameter int          NLINES      = 8,
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  EDGE_LINES  = 8'hFF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NLINES-1:0] i_irq_in,
    input  logic              i_en_we,
    input  logic [NLINES-1:0] i_en_wd,
    input  logic              i_ack,
    input  logic              i_eoi,
    output logic              o_intrq,
    output logic [3:0]        o_vector,
    output logic [NLINES-1:0] o_pending,
    output logic [NLINES-1:0] o_inserv
);

    localparam logic [NLINES-1:0] EDGE_MASK    = EDGE_LINES[NLINES-1:0];
    localparam logic [3:0]        VEC_SPURIOUS = 4'b1000;

    // Synchroniser chain: r_sync[0] faces the pins, the last stage is "s".
    logic [NLINES-1:0] r_sync [SYNC_STAGES];

    logic [NLINES-1:0] r_prev;
    logic [NLINES-1:0] r_pending;
    logic [NLINES-1:0] r_enable;
    logic              r_intrq;
    logic [3:0]        r_vector;

    logic [NLINES-1:0] w_s;
    logic [NLINES-1:0] w_rise;
    logic [NLINES-1:0] w_inserv;
    logic [NLINES-1:0] w_eligible;
    logic [NLINES-1:0] w_win_oh;
    logic [2:0]        w_win_idx;
    logic              w_any;
    logic              w_take;
    logic [NLINES-1:0] w_pending_nxt;

    // -------------------------------------------------------------------------
    // Input synchronisers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= i_irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_prev;

    // -------------------------------------------------------------------------
    // Eligibility: an in-service line masks itself and every lower-priority
    // line. Without nesting support w_inserv is constant zero, so this reduces
    // to pending & enable.
    // -------------------------------------------------------------------------
    always_comb begin
        logic v_blocked;
        v_blocked  = 1'b0;
        w_eligible = '0;
        for (int i = 0; i < NLINES; i++) begin
            v_blocked     = v_blocked | w_inserv[i];
            w_eligible[i] = r_pending[i] & r_enable[i] & ~v_blocked;
        end
    end

    // Fixed priority: scan from the top so the lowest eligible index wins.
    always_comb begin
        w_win_idx = '0;
        w_win_oh  = '0;
        for (int i = NLINES - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_win_idx   = 3'(i);
                w_win_oh    = '0;
                w_win_oh[i] = 1'b1;
            end
        end
    end

    assign w_any  = |w_eligible;
    assign w_take = i_ack & w_any;

    // Edge lines hold until acknowledged. A fresh edge in the ACK cycle keeps
    // the bit set so that the edge is not lost. Level lines simply follow s.
    always_comb begin
        w_pending_nxt = r_pending;
        for (int i = 0; i < NLINES; i++) begin
            if (EDGE_MASK[i]) begin
                w_pending_nxt[i] = (r_pending[i] & ~(w_take & w_win_oh[i])) | w_rise[i];
            end else begin
                w_pending_nxt[i] = w_s[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Main state
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev    <= '0;
            r_pending <= '0;
            r_enable  <= '0;
            r_intrq   <= 1'b0;
            r_vector  <= VEC_SPURIOUS;
        end else begin
            r_prev    <= w_s;
            r_pending <= w_pending_nxt;
            if (i_en_we) begin
                r_enable <= i_en_wd;
            end
            // The request drops for one cycle after ACK so that the sequencer
            // never sees a stale request from the line it just took.
            r_intrq <= w_any & ~i_ack;
            if (i_ack) begin
                // A withdrawn request still gets a vector, marked spurious.
                r_vector <= w_any ? {1'b0, w_win_idx} : VEC_SPURIOUS;
            end
        end
    end

    // -------------------------------------------------------------------------
    // In-service tracking
    // -------------------------------------------------------------------------
`ifdef INTCTL_NEST_EN
    logic [NLINES-1:0] r_inserv;
    logic [NLINES-1:0] w_eoi_clr;

    // EOI retires the lowest set bit. That bit is the most recently nested
    // and highest-priority routine. x & (~x + 1) isolates it.
    assign w_eoi_clr = i_eoi ? (r_inserv & (~r_inserv + NLINES'(1))) : '0;

    // A winner always has a lower index than every in-service bit, so the set
    // and clear below never collide on the same bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inserv <= '0;
        end else begin
            r_inserv <= (r_inserv & ~w_eoi_clr) | (w_take ? w_win_oh : '0);
        end
    end

    assign w_inserv = r_inserv;
`else
    logic w_unused;
    assign w_unused = i_eoi;
    assign w_inserv = '0;
`endif

    assign o_intrq   = r_intrq;
    assign o_vector  = r_vector;
    assign o_pending = r_pending;
    assign o_inserv  = w_inserv;

endmodule

// File: tb/tb_intctl.sv
// -----------------------------------------------------------------------------
// tb_intctl -- directed scenarios followed by randomized traffic. All outputs
// are compared each cycle against a behavioural model of the controller.
// -----------------------------------------------------------------------------
module tb_intctl;

    localparam int         NL   = 8;
    localparam int         SS   = 2;
    localparam logic [7:0] EDGE = 8'hBF;   // line 6 is level-sensitive
`ifdef INTCTL_NEST_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irq   = '0;
    logic       en_we = 1'b0;
    logic [7:0] en_wd = '0;
    logic       ack   = 1'b0;
    logic       eoi   = 1'b0;
    logic       intrq;
    logic [3:0] vec;
    logic [7:0] pend;
    logic [7:0] insv;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    intctl #(
        .NLINES      (NL),
        .SYNC_STAGES (SS),
        .EDGE_LINES  (EDGE)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_irq_in  (irq),
        .i_en_we   (en_we),
        .i_en_wd   (en_wd),
        .i_ack     (ack),
        .i_eoi     (eoi),
        .o_intrq   (intrq),
        .o_vector  (vec),
        .o_pending (pend),
        .o_inserv  (insv)
    );

    // ---------------- behavioural model ----------------
    logic [7:0] m_q[$];      // raw input delay line, front = synchronised value
    logic [7:0] m_prev;
    logic [7:0] m_pend;
    logic [7:0] m_en;
    logic [7:0] m_insv;
    logic       m_intrq;
    logic [3:0] m_vec;

    task automatic model_reset();
        m_q.delete();
        for (int k = 0; k < SS; k++) m_q.push_back(8'h00);
        m_prev  = '0;
        m_pend  = '0;
        m_en    = '0;
        m_insv  = '0;
        m_intrq = 1'b0;
        m_vec   = 4'h8;
    endtask

    // Highest-priority line that may be taken now, or -1.
    function automatic int m_winner();
        for (int i = 0; i < NL; i++) begin
            if (NEST && m_insv[i]) return -1;
            if (m_pend[i] && m_en[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        int         w;
        logic [7:0] s;
        logic [7:0] np;
        logic [7:0] ni;
        w  = m_winner();
        s  = m_q[0];
        np = '0;
        for (int i = 0; i < NL; i++) begin
            if (EDGE[i]) np[i] = (m_pend[i] && !(ack && w == i)) || (s[i] && !m_prev[i]);
            else         np[i] = s[i];
        end
        ni = m_insv;
        if (NEST && eoi) begin
            for (int i = 0; i < NL; i++) begin
                if (ni[i]) begin
                    ni[i] = 1'b0;
                    break;
                end
            end
        end
        if (ack) begin
            if (w >= 0) begin
                m_vec = {1'b0, 3'(w)};
                if (NEST) ni[w] = 1'b1;
            end else begin
                m_vec = 4'h8;
            end
        end
        m_intrq = (w >= 0) && !ack;
        if (en_we) m_en = en_wd;
        m_prev = s;
        m_pend = np;
        m_insv = ni;
        void'(m_q.pop_front());
        m_q.push_back(irq);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("intrq",   8'(intrq), 8'(m_intrq));
        chk("vector",  8'(vec),   8'(m_vec));
        chk("pending", pend,      m_pend);
        chk("inserv",  insv,      m_insv);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_intrq",  8'(intrq), 8'd0);
        chk("rst_vector", 8'(vec),   8'h08);
        chk("rst_pend",   pend,      8'h00);
        chk("rst_insv",   insv,      8'h00);
        #2 rst_n = 1'b1;

        // 1: single edge on line 3
        en_we = 1'b1; en_wd = 8'hFF; tick(); en_we = 1'b0;
        irq = 8'h08; tick(); irq = 8'h00; tick(); tick();
        chk("t1_pend_e3", pend, 8'h08);
        chk("t1_intrq_e3", 8'(intrq), 8'd0);
        tick();
        chk("t1_intrq_e4", 8'(intrq), 8'd1);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("t1_vec", 8'(vec), 8'h03);
        chk("t1_insv", insv, NEST ? 8'h08 : 8'h00);
        chk("t1_pend_clr", pend, 8'h00);
        chk("t1_intrq_ack", 8'(intrq), 8'd0);
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk("t1_insv_eoi", insv, 8'h00);

        // 2: lines 5 and 1 together
        irq = 8'h22; tick(); irq = 8'h00; tick(); tick(); tick();
        ack = 1'b1; tick(); ack = 1'b0;
        chk("t2_vec1", 8'(vec), 8'h01);
        tick(); tick();
        chk("t2_wait", 8'(intrq), NEST ? 8'd0 : 8'd1);
        eoi = 1'b1; tick(); eoi = 1'b0; tick();
        chk("t2_intrq", 8'(intrq), 8'd1);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("t2_vec5", 8'(vec), 8'h05);
        eoi = 1'b1; tick(); eoi = 1'b0;

        // 3: line 2 nests over line 4
        irq = 8'h10; tick(); irq = 8'h00; tick(); tick(); tick();
        ack = 1'b1; tick(); ack = 1'b0;
        chk("t3_vec4", 8'(vec), 8'h04);
        irq = 8'h04; tick(); irq = 8'h00; tick(); tick(); tick();
        chk("t3_intrq", 8'(intrq), 8'd1);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("t3_vec2", 8'(vec), 8'h02);
        chk("t3_insv2", insv, NEST ? 8'h14 : 8'h00);
        eoi = 1'b1; tick();
        chk("t3_insv_eoi1", insv, NEST ? 8'h10 : 8'h00);
        tick(); eoi = 1'b0;
        chk("t3_insv_eoi2", insv, 8'h00);

        // 4: level line 6
        irq = 8'h40; tick(); tick(); tick(); tick();
        chk("t4_intrq", 8'(intrq), 8'd1);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("t4_vec6", 8'(vec), 8'h06);
        chk("t4_pend_lvl", pend, 8'h40);
        tick();
        chk("t4_wait", 8'(intrq), NEST ? 8'd0 : 8'd1);
        eoi = 1'b1; tick(); eoi = 1'b0; tick();
        chk("t4_reassert", 8'(intrq), 8'd1);
        irq = 8'h00; tick(); tick(); tick();
        chk("t4_pend_drop", pend, 8'h00);
        chk("t4_intrq_hold", 8'(intrq), 8'd1);
        tick();
        chk("t4_intrq_fall", 8'(intrq), 8'd0);

        // 5: enable gating and spurious acknowledge
        en_we = 1'b1; en_wd = 8'h00; tick(); en_we = 1'b0;
        irq = 8'h01; tick(); irq = 8'h00; tick(); tick();
        chk("t5_pend", pend, 8'h01);
        tick();
        chk("t5_masked", 8'(intrq), 8'd0);
        en_we = 1'b1; en_wd = 8'h01; tick(); en_we = 1'b0; tick();
        chk("t5_enabled", 8'(intrq), 8'd1);
        en_we = 1'b1; en_wd = 8'h00; tick(); en_we = 1'b0;
        ack = 1'b1; tick(); ack = 1'b0;
        chk("t5_spurious", 8'(vec), 8'h08);
        chk("t5_insv", insv, 8'h00);
        chk("t5_pend_kept", pend, 8'h01);

        // 6: asynchronous reset with live state
        en_we = 1'b1; en_wd = 8'hFF; tick(); en_we = 1'b0; tick();
        ack = 1'b1; tick(); ack = 1'b0;
        chk("t6_vec0", 8'(vec), 8'h00);
        irq = 8'h80; tick(); irq = 8'h00; tick(); tick();
        chk("t6_pend", pend, 8'h80);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_pend_rst",  pend,      8'h00);
        chk("t6_insv_rst",  insv,      8'h00);
        chk("t6_intrq_rst", 8'(intrq), 8'd0);
        chk("t6_vec_rst",   8'(vec),   8'h08);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Randomized traffic
        en_we = 1'b1; en_wd = 8'hFF; tick(); en_we = 1'b0;
        for (int n = 0; n < 600; n++) begin
            logic [7:0] flip;
            flip = '0;
            for (int b = 0; b < NL; b++) flip[b] = ($urandom_range(0, 7) == 0);
            irq   = irq ^ flip;
            en_we = ($urandom_range(0, 15) == 0);
            en_wd = 8'($urandom) | 8'($urandom);
            ack   = (intrq && ($urandom_range(0, 1) == 1)) || ($urandom_range(0, 19) == 0);
            eoi   = ($urandom_range(0, 5) == 0);
            tick();
        end
        irq = '0; en_we = 1'b0; ack = 1'b0; eoi = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/intctl.md
Name: intctl

Overview:
- Interrupt controller directly upstream of the sequencer. It takes NLINES external interrupt sources and drives the sequencer's single INTRQ input.
- Per line it provides:
  - input synchronisation;
  - edge or level detection;
  - an enable mask;
  - fixed priority.
- The sequencer pulses ACK when it enters its first interrupt-request state. The pulse latches the winning line's vector, which the interrupt sequence consumes.
- The sequencer pulses EOI on its first interrupt-return state.

Parameters:
- NLINES, 8: number of interrupt lines; 2..8; line 0 has highest priority.
- SYNC_STAGES, 2: synchroniser flops per line; minimum 2.
- EDGE_LINES, 8'hFF: per-line mode; 1 = rising-edge latched, 0 = level.

Ports:
- CLOCK  in  1  system clock; all state updates on its rising edge.
- RESET_N  in  1  reset; one clock; asynchronous, active-low.
- IRQ_IN  in  NLINES  raw asynchronous interrupt sources, active-high.
- EN_WE  in  1  write strobe for the enable register.
- EN_WD  in  NLINES  enable register write data.
- ACK  in  1  one-cycle pulse from the sequencer (interrupt-request state 1).
- EOI  in  1  one-cycle pulse from the sequencer (interrupt-return state 1).
- INTRQ  out  1  registered request to the sequencer.
- VECTOR  out  4  {spurious, line[2:0]}, latched at ACK.
- PENDING  out  NLINES  pending register, for debug/status reads.
- INSERV  out  NLINES  in-service register.

Behaviour:

Reset (RESET_N low, asynchronous):
- Clears synchronisers, edge-history flops, PENDING, ENABLE, INSERV and INTRQ.
- Sets VECTOR to 4'b1000 (spurious).
- Outputs hold these values until the first clock edge after RESET_N rises.
- Reset asserted mid-interrupt discards all pending and in-service state. No request survives.

Synchronisation and pending:
- Each IRQ_IN bit passes through SYNC_STAGES flops, giving s.
- Edge line: PENDING[i] sets when s[i]=1 and the previous s[i]=0. It clears only on ACK selecting line i.
  - If a new edge arrives in the same cycle as that ACK, set wins: PENDING stays 1.
- Level line: PENDING[i] <= s[i] every cycle. ACK does not clear it; the source must drop it.
- Latency: IRQ_IN rises before edge 1. PENDING is set after edge SYNC_STAGES+1. INTRQ rises after edge SYNC_STAGES+2.

Eligibility:
- eligible[i] = PENDING[i] & ENABLE[i] & (no INSERV bit at index <= i).
- winner = lowest-index eligible line.

INTRQ:
- INTRQ <= |eligible & ~ACK.
- It is forced low in the cycle after ACK, then re-evaluates from the updated state.

ACK cycle (edge at end of the ACK-high cycle):
- If eligible is non-zero:
  - VECTOR <= {0, winner};
  - INSERV[winner] <= 1;
  - PENDING[winner] cleared if the line is an edge line.
- If eligible is zero (the request withdrew): VECTOR <= 4'b1000; no other state changes.
- VECTOR holds until the next ACK.

EOI:
- Clears the lowest-index set INSERV bit.
- With INSERV all zero, EOI has no effect.

ACK and EOI in the same cycle:
- Eligibility uses pre-update state.
- Both updates apply at the same edge. They cannot target the same bit, because the winner always has a lower index than every in-service bit.

Enable register:
- EN_WE writes ENABLE <= EN_WD.
- The new value affects eligibility from the next cycle.
- Clearing an enable does not clear PENDING.

Unused lines:
- Lines >= NLINES read as 0 everywhere.

Optional Feature:
- Macro: INTCTL_NEST_EN.
- Defined:
  - INSERV tracking and the in-service priority mask are built as described above.
  - A higher-priority line may interrupt a lower one in service.
  - An equal or lower-priority line waits for EOI.
- Undefined:
  - INSERV register is not built; the INSERV port is tied to 0.
  - EOI is ignored.
  - eligible[i] = PENDING[i] & ENABLE[i].
  - Nesting control is left entirely to the PSW interrupt-enable bit in the sequencer.

Test Plan:
1. Reset, then ENABLE=8'hFF; pulse IRQ_IN[3] for 1 cycle (edge mode) -> PENDING[3]=1 after edge 3; INTRQ=1 after edge 4; ACK -> VECTOR=4'h3, INSERV=8'h08, PENDING=0; INTRQ=0 the next cycle.
2. IRQ_IN[5] and IRQ_IN[1] raised in the same cycle -> first ACK gives VECTOR=4'h1; then (NEST_EN) INTRQ stays 0 until EOI; after EOI, INTRQ=1 and the second ACK gives VECTOR=4'h5.
3. NEST_EN: line 4 in service, then IRQ_IN[2] edge -> INTRQ=1, ACK gives VECTOR=4'h2, INSERV=8'h14; EOI -> INSERV=8'h10; second EOI -> 8'h00.
4. Level line 6 (EDGE_LINES bit 6=0): hold IRQ_IN[6]=1 -> ACK gives VECTOR=4'h6; after EOI, INTRQ reasserts; drop IRQ_IN[6] -> PENDING[6]=0 after SYNC_STAGES+1 edges, INTRQ falls one cycle later.
5. ENABLE=0, edge on line 0 -> PENDING[0]=1, INTRQ=0; write ENABLE=1 -> INTRQ=1 two edges later. Then clear ENABLE before ACK and pulse ACK -> VECTOR=4'h8, INSERV unchanged.
6. Set PENDING and INSERV non-zero, then drop RESET_N asynchronously mid-cycle -> PENDING, INSERV and INTRQ read 0 immediately; VECTOR=4'h8.
